victim_cache_ctrl: RTL and testbench

// - Sequencing controller for the victim-cache tag_store. Owns every tag_store control strobe.
// - Serves one L1 request at a time:
//   - LOOKUP: probe. On a hit the entry is invalidated (exclusive swap back to L1).
//   - INSERT: install an L1 victim tag. Chooses a free way first, else a round-robin way.
//     A dirty displaced tag is written back before it is overwritten.
// - Sits between the L1 miss/evict path, tag_store and the memory writeback queue.

---
 rtl/vc_pkg.sv | 31 +++
 rtl/vc_tag_store.sv | 96 +++++++++
 rtl/vc_way_select.sv | 32 +++
 rtl/victim_cache_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_victim_cache_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_pkg.sv
// Shared types for the victim-cache controller.
//   vc_state_e : controller sequencing states
//   vc_req_e   : L1 request kind (lookup probe or victim insert)
//   rr_next    : round-robin pointer advance with wrap at num_ways-1
package vc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        LK_CHK,
        HIT_RD,
        HIT_INV,
        INS_SEL,
        INS_RD,
        INS_CHK,
        WB_REQ,
        INS_WR,
        INS_DIRTY,
        RESP
    } vc_state_e;

    typedef enum logic {
        REQ_LOOKUP = 1'b0,
        REQ_INSERT = 1'b1
    } vc_req_e;

    function automatic int rr_next(input int ptr, input int num_ways);
        return (ptr >= num_ways - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/vc_tag_store.sv
// Victim-cache tag store: per-way tag, valid and dirty bits.
// Read and lookup results are registered (visible the cycle after the enable);
// write / valid_clear / dirty_set / dirty_clear update state at the end of
// the enable cycle.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   tag_in, way_index_in       : operand tag and way
//   write_en                   : install tag_in into way, mark valid
//   read_en                    : capture valid/dirty/tag of way
//   lookup_en                  : associative search for tag_in
//   valid_clear                : invalidate way
//   dirty_set, dirty_clear     : set / clear dirty bit of way
//   hit, hit_way_index         : lookup result (lowest matching way)
//   valid_read, dirty_read, tag_read : read result
module vc_tag_store #(
    parameter  int TAG_WIDTH = 4,
    parameter  int NUM_WAYS  = 4,
    localparam int WAY_W     = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic [WAY_W-1:0]     way_index_in,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic                 lookup_en,
    input  logic                 valid_clear,
    input  logic                 dirty_set,
    input  logic                 dirty_clear,
    output logic                 hit,
    output logic [WAY_W-1:0]     hit_way_index,
    output logic                 valid_read,
    output logic                 dirty_read,
    output logic [TAG_WIDTH-1:0] tag_read
);

    logic [TAG_WIDTH-1:0] r_tag [NUM_WAYS];
    logic [NUM_WAYS-1:0]  r_valid;
    logic [NUM_WAYS-1:0]  r_dirty;
    logic [NUM_WAYS-1:0]  w_match;
    logic [WAY_W-1:0]     w_hit_way;

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_tag[gi] == tag_in);
        end
    endgenerate

    always_comb begin
        w_hit_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_way = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                r_tag[i] <= '0;
            end
            r_valid       <= '0;
            r_dirty       <= '0;
            hit           <= 1'b0;
            hit_way_index <= '0;
            valid_read    <= 1'b0;
            dirty_read    <= 1'b0;
            tag_read      <= '0;
        end else begin
            if (write_en) begin
                r_tag[way_index_in]   <= tag_in;
                r_valid[way_index_in] <= 1'b1;
            end
            if (valid_clear) begin
                r_valid[way_index_in] <= 1'b0;
            end
            if (dirty_set) begin
                r_dirty[way_index_in] <= 1'b1;
            end
            if (dirty_clear) begin
                r_dirty[way_index_in] <= 1'b0;
            end
            if (lookup_en) begin
                hit           <= |w_match;
                hit_way_index <= w_hit_way;
            end
            if (read_en) begin
                valid_read <= r_valid[way_index_in];
                dirty_read <= r_dirty[way_index_in];
                tag_read   <= r_tag[way_index_in];
            end
        end
    end

endmodule

// File: rtl/vc_way_select.sv
// Insert-way chooser for the victim cache (purely combinational).
// Ports:
//   valid_shadow : per-way occupancy as tracked by the controller
//   rr_ptr       : round-robin replacement pointer
//   sel_way      : lowest free way if any, otherwise rr_ptr
//   sel_free     : 1 when sel_way is a free (unoccupied) way
module vc_way_select #(
    parameter  int NUM_WAYS = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid_shadow,
    input  logic [WAY_W-1:0]    rr_ptr,
    output logic [WAY_W-1:0]    sel_way,
    output logic                sel_free
);

    logic [WAY_W-1:0] w_free_way;

    // Scan from the top down so the last assignment wins: lowest free index.
    always_comb begin
        w_free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_shadow[i]) begin
                w_free_way = WAY_W'(i);
            end
        end
    end

    assign sel_free = ~&valid_shadow;
    assign sel_way  = sel_free ? w_free_way : rr_ptr;

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim-cache sequencing controller. Serves one L1 request at a time and
// owns every tag_store strobe.
//   LOOKUP : probe; a hit is read back and invalidated (exclusive swap to L1).
//   INSERT : install a victim tag into the lowest free way, else the
//            round-robin way; a dirty displaced tag is written back first.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   req_valid/req_ready               : L1 request handshake (ready only in IDLE)
//   req_type, req_tag, req_dirty      : request kind, tag, dirty (INSERT only)
//   rsp_valid, rsp_hit, rsp_dirty, rsp_way : registered one-cycle response
//   wb_valid/wb_ready, wb_tag         : writeback of a displaced dirty tag
//   ts_* outputs                      : tag_store strobes, tag and way operands
//   ts_hit, ts_hit_way, ts_valid_read, ts_dirty_read, ts_tag_read : tag_store results
module victim_cache_ctrl
    import vc_pkg::*;
#(
    parameter  int TAG_WIDTH = 4,
    parameter  int NUM_WAYS  = 4,
    localparam int WAY_W     = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_type,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 req_dirty,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic                 rsp_dirty,
    output logic [WAY_W-1:0]     rsp_way,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic                 ts_write_en,
    output logic                 ts_read_en,
    output logic                 ts_lookup_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag,
    output logic [WAY_W-1:0]     ts_way,
    input  logic                 ts_hit,
    input  logic [WAY_W-1:0]     ts_hit_way,
    input  logic                 ts_valid_read,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read
);

    vc_state_e            r_state;
    vc_state_e            w_state_next;
    vc_req_e              r_req_type;
    logic [TAG_WIDTH-1:0] r_req_tag;
    logic                 r_req_dirty;
    logic [WAY_W-1:0]     r_way;
    logic [WAY_W-1:0]     r_rr_ptr;
    logic                 r_replace;      // chosen insert way was occupied
    logic                 r_hit;
    logic                 r_hit_dirty;
    logic [NUM_WAYS-1:0]  r_valid_shadow; // controller's copy of tag_store valid bits

    logic                 r_rsp_valid;
    logic                 r_rsp_hit;
    logic                 r_rsp_dirty;
    logic [WAY_W-1:0]     r_rsp_way;
    logic                 r_wb_valid;
    logic [TAG_WIDTH-1:0] r_wb_tag;

    logic [WAY_W-1:0]     w_sel_way;
    logic                 w_sel_free;
    logic                 w_accept;
    logic                 w_in_resp;

    vc_way_select #(
        .NUM_WAYS (NUM_WAYS)
    ) u_way_select (
        .valid_shadow (r_valid_shadow),
        .rr_ptr       (r_rr_ptr),
        .sel_way      (w_sel_way),
        .sel_free     (w_sel_free)
    );

    assign req_ready = (r_state == IDLE);
    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_in_resp = (r_state == RESP);

    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_dirty = r_rsp_dirty;
    assign rsp_way   = r_rsp_way;
    assign wb_valid  = r_wb_valid;
    assign wb_tag    = r_wb_tag;

    // Operands are simply the latched request tag and the working way; the
    // strobes decide whether tag_store looks at them.
    assign ts_tag = r_req_tag;
    assign ts_way = r_way;

    // Next-state and Moore strobes: at most one strobe per state.
    always_comb begin
        w_state_next   = r_state;
        ts_write_en    = 1'b0;
        ts_read_en     = 1'b0;
        ts_lookup_en   = 1'b0;
        ts_valid_clear = 1'b0;
        ts_dirty_set   = 1'b0;
        ts_dirty_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = (vc_req_e'(req_type) == REQ_INSERT) ? INS_SEL : LOOKUP;
                end
            end
            LOOKUP: begin
                ts_lookup_en = 1'b1;
                w_state_next = LK_CHK;
            end
            LK_CHK: begin
                w_state_next = ts_hit ? HIT_RD : RESP;
            end
            HIT_RD: begin
                ts_read_en   = 1'b1;
                w_state_next = HIT_INV;
            end
            HIT_INV: begin
                ts_valid_clear = 1'b1;
                w_state_next   = RESP;
            end
            INS_SEL: begin
                w_state_next = w_sel_free ? INS_WR : INS_RD;
            end
            INS_RD: begin
                ts_read_en   = 1'b1;
                w_state_next = INS_CHK;
            end
            INS_CHK: begin
                w_state_next = (ts_valid_read && ts_dirty_read) ? WB_REQ : INS_WR;
            end
            WB_REQ: begin
                if (wb_ready) begin
                    w_state_next = INS_WR;
                end
            end
            INS_WR: begin
                ts_write_en  = 1'b1;
                w_state_next = INS_DIRTY;
            end
            INS_DIRTY: begin
                if (r_req_dirty) begin
                    ts_dirty_set = 1'b1;
                end else begin
                    ts_dirty_clear = 1'b1;
                end
                w_state_next = RESP;
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_req_type     <= REQ_LOOKUP;
            r_req_tag      <= '0;
            r_req_dirty    <= 1'b0;
            r_way          <= '0;
            r_rr_ptr       <= '0;
            r_replace      <= 1'b0;
            r_hit          <= 1'b0;
            r_hit_dirty    <= 1'b0;
            r_valid_shadow <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_hit      <= 1'b0;
            r_rsp_dirty    <= 1'b0;
            r_rsp_way      <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_tag       <= '0;
        end else begin
            r_state <= w_state_next;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_type  <= vc_req_e'(req_type);
                        r_req_tag   <= req_tag;
                        r_req_dirty <= req_dirty;
                        r_hit       <= 1'b0;
                        r_hit_dirty <= 1'b0;
                    end
                end
                LK_CHK: begin
                    r_hit <= ts_hit;
                    if (ts_hit) begin
                        r_way <= ts_hit_way;
                    end
                end
                HIT_INV: begin
                    r_hit_dirty           <= ts_dirty_read;
                    r_valid_shadow[r_way] <= 1'b0;
                end
                INS_SEL: begin
                    r_way     <= w_sel_way;
                    r_replace <= ~w_sel_free;
                end
                INS_CHK: begin
                    // Read data is valid here, so capture the displaced tag now
                    // and hold it for the whole writeback handshake.
                    if (ts_valid_read && ts_dirty_read) begin
                        r_wb_valid <= 1'b1;
                        r_wb_tag   <= ts_tag_read;
                    end
                end
                WB_REQ: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_wb_tag   <= '0;
                    end
                end
                INS_WR: begin
                    r_valid_shadow[r_way] <= 1'b1;
                    // Filling a free way leaves the replacement order untouched.
                    if (r_replace) begin
                        r_rr_ptr <= WAY_W'(rr_next(int'(r_rr_ptr), NUM_WAYS));
                    end
                end
                default: begin
                end
            endcase

            // Response is registered off RESP, so it appears in the IDLE cycle
            // that follows.
            r_rsp_valid <= w_in_resp;
            r_rsp_hit   <= w_in_resp && r_hit;
            r_rsp_dirty <= w_in_resp && r_hit && r_hit_dirty;
            r_rsp_way   <= (w_in_resp && (r_hit || (r_req_type == REQ_INSERT))) ? r_way : '0;
        end
    end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
module tb_victim_cache_ctrl;
    import vc_pkg::*;

    localparam int TW = 4;
    localparam int NW = 4;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_type, req_dirty;
    logic [TW-1:0] req_tag;
    logic          rsp_valid, rsp_hit, rsp_dirty;
    logic [WW-1:0] rsp_way;
    logic          wb_valid, wb_ready;
    logic [TW-1:0] wb_tag;
    logic          ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear;
    logic [TW-1:0] ts_tag;
    logic [WW-1:0] ts_way;
    logic          ts_hit, ts_valid_read, ts_dirty_read;
    logic [WW-1:0] ts_hit_way;
    logic [TW-1:0] ts_tag_read;

    always #5 clk = ~clk;

    victim_cache_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_tag(req_tag), .req_dirty(req_dirty),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dirty(rsp_dirty), .rsp_way(rsp_way),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .ts_write_en(ts_write_en), .ts_read_en(ts_read_en), .ts_lookup_en(ts_lookup_en),
        .ts_valid_clear(ts_valid_clear), .ts_dirty_set(ts_dirty_set), .ts_dirty_clear(ts_dirty_clear),
        .ts_tag(ts_tag), .ts_way(ts_way),
        .ts_hit(ts_hit), .ts_hit_way(ts_hit_way), .ts_valid_read(ts_valid_read),
        .ts_dirty_read(ts_dirty_read), .ts_tag_read(ts_tag_read)
    );

    vc_tag_store #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) u_ts (
        .clk(clk), .rst_n(~rst),
        .tag_in(ts_tag), .way_index_in(ts_way),
        .write_en(ts_write_en), .read_en(ts_read_en), .lookup_en(ts_lookup_en),
        .valid_clear(ts_valid_clear), .dirty_set(ts_dirty_set), .dirty_clear(ts_dirty_clear),
        .hit(ts_hit), .hit_way_index(ts_hit_way),
        .valid_read(ts_valid_read), .dirty_read(ts_dirty_read), .tag_read(ts_tag_read)
    );

    typedef struct {
        logic          hit;
        logic          dirty;
        logic [WW-1:0] way;
        int            lat;
    } rsp_exp_t;

    rsp_exp_t      rsp_q[$];
    int            acc_q[$];
    logic [TW-1:0] wb_q[$];

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int n_rsp   = 0;
    int n_acc   = 0;
    int exp_acc = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Accept monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            acc_q.push_back(cyc + 1);
            n_acc++;
        end
    end

    // Response monitor / scoreboard.
    always @(negedge clk) begin : rsp_mon
        rsp_exp_t e;
        int       a;
        if (!rst && rsp_valid) begin
            n_rsp++;
            if (rsp_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp hit=%0b way=%0d, expected no response", rsp_hit, rsp_way);
            end else begin
                e = rsp_q.pop_front();
                a = acc_q.pop_front();
                check("rsp_hit_dirty_way", 32'({rsp_hit, rsp_dirty, rsp_way}), 32'({e.hit, e.dirty, e.way}));
                check("rsp_latency", 32'(cyc - a), 32'(e.lat));
                $display("rsp: hit=%0b dirty=%0b way=%0d latency=%0d", rsp_hit, rsp_dirty, rsp_way, cyc - a);
            end
        end
    end

    // Writeback monitor: every completed writeback must be one we expected.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (wb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_tag=0x%0h, expected no writeback", wb_tag);
            end else begin
                check("wb_tag", 32'(wb_tag), 32'(wb_q.pop_front()));
            end
        end
    end

    // At most one tag_store strobe in any cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_onehot",
                  32'($countones({ts_write_en, ts_read_en, ts_lookup_en,
                                  ts_valid_clear, ts_dirty_set, ts_dirty_clear}) <= 1),
                  32'd1);
        end
    end

    task automatic issue(input logic t, input logic [TW-1:0] tag, input logic d);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_type  = t;
        req_tag   = tag;
        req_dirty = d;
        exp_acc++;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (n_rsp >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL rsp_timeout: got %0d responses, expected %0d", n_rsp, target);
    endtask

    task automatic txn(input logic t, input logic [TW-1:0] tag, input logic d,
                       input logic eh, input logic ed, input logic [WW-1:0] ew, input int el);
        int tgt;
        tgt = n_rsp + 1;
        $display("txn: %s tag=0x%0h dirty=%0b -> expect hit=%0b dirty=%0b way=%0d latency=%0d",
                 t ? "INSERT" : "LOOKUP", tag, d, eh, ed, ew, el);
        rsp_q.push_back('{hit: eh, dirty: ed, way: ew, lat: el});
        issue(t, tag, d);
        wait_rsp(tgt);
    endtask

    task automatic wait_wb_valid();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wb_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL wb_timeout: got wb_valid=0, expected 1 within 30 cycles");
    endtask

    localparam logic LK = 1'b0;
    localparam logic IN = 1'b1;

    initial begin : stim
        logic [22:0] outs;
        int          tgt;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_type  = 1'b0;
        req_tag   = '0;
        req_dirty = 1'b0;
        wb_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outs = {req_ready, rsp_valid, rsp_hit, rsp_dirty, rsp_way, wb_valid, wb_tag,
                ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear,
                ts_tag, ts_way};
        check("reset_outputs", 32'(outs), 32'h0040_0000);
        rst = 1'b0;

        // Inserts into an empty cache fill ways from the bottom.
        txn(IN, 4'hA, 1'b0, 1'b0, 1'b0, 2'd0, 4);
        txn(IN, 4'hB, 1'b0, 1'b0, 1'b0, 2'd1, 4);
        txn(IN, 4'hC, 1'b0, 1'b0, 1'b0, 2'd2, 4);

        // Hit-and-invalidate, then a repeat probe misses.
        txn(IN, 4'hD, 1'b1, 1'b0, 1'b0, 2'd3, 4);
        txn(LK, 4'hD, 1'b0, 1'b1, 1'b1, 2'd3, 5);
        txn(LK, 4'hD, 1'b0, 1'b0, 1'b0, 2'd0, 3);

        // Rebuild a full cache with way 0 dirty (tag 1).
        txn(LK, 4'hA, 1'b0, 1'b1, 1'b0, 2'd0, 5);
        txn(IN, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0, 4);
        txn(IN, 4'h3, 1'b0, 1'b0, 1'b0, 2'd3, 4);

        // Dirty replacement of way 0 with a 3-cycle writeback stall.
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        tgt = n_rsp + 1;
        $display("txn: INSERT tag=0xe dirty=0 -> expect writeback tag=0x1, way=0, latency=10");
        rsp_q.push_back('{hit: 1'b0, dirty: 1'b0, way: 2'd0, lat: 10});
        wb_q.push_back(4'h1);
        issue(IN, 4'hE, 1'b0);
        wait_wb_valid();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("wb_hold_valid", 32'(wb_valid), 32'd1);
            check("wb_hold_tag", 32'(wb_tag), 32'h1);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        wait_rsp(tgt);

        // Clean replacements walk the round-robin pointer 1,2,3,0.
        txn(IN, 4'h4, 1'b0, 1'b0, 1'b0, 2'd1, 6);
        txn(IN, 4'h5, 1'b0, 1'b0, 1'b0, 2'd2, 6);
        txn(IN, 4'h6, 1'b0, 1'b0, 1'b0, 2'd3, 6);
        txn(IN, 4'h7, 1'b0, 1'b0, 1'b0, 2'd0, 6);

        // Handshake: req_valid held across a busy op and into the next one.
        tgt = n_rsp + 2;
        $display("txn: LOOKUP tag=0x5 held valid -> expect hit way=2 latency=5, then miss latency=3");
        rsp_q.push_back('{hit: 1'b1, dirty: 1'b0, way: 2'd2, lat: 5});
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_type  = LK;
        req_tag   = 4'h5;
        req_dirty = 1'b0;
        exp_acc  += 2;
        @(negedge clk);
        check("hs_ready_idle", 32'(req_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            check("hs_busy_ready", 32'(req_ready), 32'd0);
        end
        check("hs_ready_with_rsp", 32'(req_ready), 32'd1);
        rsp_q.push_back('{hit: 1'b0, dirty: 1'b0, way: 2'd0, lat: 3});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(tgt);

        // Prepare a dirty way under the round-robin pointer (way 1).
        txn(LK, 4'h4, 1'b0, 1'b1, 1'b0, 2'd1, 5);
        txn(IN, 4'h9, 1'b1, 1'b0, 1'b0, 2'd1, 4);
        txn(IN, 4'h8, 1'b0, 1'b0, 1'b0, 2'd2, 4);

        // Reset while the writeback request is outstanding.
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        $display("txn: INSERT tag=0xa dirty=0 -> expect writeback tag=0x9, aborted by reset");
        issue(IN, 4'hA, 1'b0);
        wait_wb_valid();
        check("abort_wb_tag", 32'(wb_tag), 32'h9);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_wb_drop", 32'(wb_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        acc_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wb_ready = 1'b1;
        txn(IN, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4);

        repeat (3) @(posedge clk);
        check("accept_count", 32'(n_acc), 32'(exp_acc));
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
